step_sweep_controller: RTL and testbench
========================================

# step_sweep_controller

Sequencer that owns the DAC step output of the step generator. Selects the step-advance source (debounced external pulse tick or an internal programmable timer), runs up-sawtooth, down-sawtooth or triangle sweeps over the selected step count, and supports continuous or single-shot runs. Sits between the debounced edge detector / step selector and the external DAC pins, taking over the sequencing role of the plain step counter.

## Interface
- TIMER_W, 24, width of internal tick period counter
- MAX_N, 10, hard upper limit on step count (steps 0..MAX_N-1)
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-low reset; sampled on rising clk edge
- ext_tick  in  1  one-cycle pulse from debouncer
- start  in  1  level-sampled; rising-edge detected internally
- stop  in  1  level-sampled; rising-edge detected internally
- src_sel  in  1  0 = ext_tick advances, 1 = internal timer advances
- oneshot  in  1  1 = stop after one full sweep period
- mode  in  2  0 up-saw, 1 down-saw, 2 triangle, 3 reserved (treated as 0)
- max_steps  in  4  step count N from step selector
- period  in  TIMER_W  internal tick period in clk cycles
- step_out  out  4  current step, binary
- dac_wr  out  1  one-cycle strobe, high in the cycle step_out takes a new value
- busy  out  1  high in RUN
- cycle_done  out  1  one-cycle pulse at end of each sweep period
- state_out  out  2  0 IDLE, 1 RUN, 2 HOLD

## Operation
- Effective N: max_steps 0 -> 1; max_steps > MAX_N -> MAX_N; else max_steps. N, mode, oneshot, src_sel latched on accepted start; input changes during RUN ignored until next start.
- Start value: up-saw and triangle 0; down-saw N-1.
- FSM:
  - IDLE: start edge (and no stop edge same cycle) -> RUN; load start value, assert dac_wr, clear timer.
  - RUN: on each advance event step per mode. Stop edge -> IDLE, step_out holds its value. Oneshot and sweep end -> HOLD.
  - HOLD: step_out frozen at final value; start edge -> RUN (reload); stop edge -> IDLE.
- Advance event: src_sel=0 -> ext_tick high; src_sel=1 -> timer expiry. Timer counts 0..P-1, P = period (period 0 treated as 1, i.e. every cycle); expiry when count = P-1, then wraps to 0. Timer free-runs only in RUN; held at 0 otherwise.
- Up-saw: 0,1,..,N-1,0,... ; cycle_done on the wrap N-1 -> 0.
- Down-saw: N-1,..,0,N-1,... ; cycle_done on wrap 0 -> N-1.
- Triangle: 0,1,..,N-1,N-2,..,1,0,1,...; direction flips at ends without repeating the endpoint; cycle_done on the 1 -> 0 transition. N=1: stays 0, cycle_done every advance. N=2: 0,1,0,1.
- Oneshot: the advance that produces cycle_done moves to HOLD; step_out shows the wrap target (start value) and dac_wr pulses.
- Simultaneous start and stop edges: stop wins. Stop and advance in same cycle: stop wins, no step update, no dac_wr.
- ext_tick ignored when src_sel=1 and vice versa; ext_tick outside RUN ignored.

## Timing
- Reset (rst=0 at clk edge): step_out 0, dac_wr 0, busy 0, cycle_done 0, state_out 0, timer 0, direction up, edge detectors cleared. Reset mid-run aborts immediately; no dac_wr on reset.
- All outputs registered.
- start edge sampled in cycle k -> RUN, step_out = start value, dac_wr high in cycle k+1.
- Advance event in cycle k -> new step_out and dac_wr in cycle k+1; cycle_done coincident with dac_wr of the wrap step.
- Internal source: first advance P cycles after RUN entry; subsequent every P cycles exactly.
- stop edge in cycle k -> state_out 0, busy 0 in cycle k+1.
- dac_wr never high two consecutive cycles unless advance events occur in consecutive cycles (P=1 or back-to-back ext_tick).

## Test plan
- Reset then start, src_sel=1, period=4, mode=0, max_steps=3 -> step_out 0,1,2,0 at 4-cycle spacing; cycle_done on 2->0; dac_wr each change.
- mode=2, max_steps=4, ext_tick pulses -> 0,1,2,3,2,1,0,1; cycle_done only on 1->0.
- oneshot=1, mode=1, max_steps=12 (clipped 10) -> 9 down to 0, then 9 with cycle_done, state_out=2, further ticks ignored.
- start and stop same cycle from IDLE -> stays IDLE, no dac_wr; stop during RUN concurrent with tick -> IDLE, step_out unchanged.
- max_steps=0, period=0 -> step_out stays 0, cycle_done every cycle after start.
- rst=0 mid-sweep at step 5 -> next cycle all outputs 0, state IDLE; max_steps change during RUN has no effect until next start.

Source files
------------

// File: rtl/step_sweep_controller.sv
// step_sweep_controller: owns the DAC step output. Picks the advance source
// (external debounced tick or internal period timer), walks up-saw, down-saw
// or triangle sweeps over N steps, and runs continuously or single-shot.
//
// Handshake: there is no valid/ready pair. start/stop are level inputs whose
// rising edges are commands; dac_wr is a one-cycle strobe in the cycle a new
// step_out value is presented. The DAC has no back-pressure.
module step_sweep_controller #(
  parameter int TIMER_W = 24,
  parameter int MAX_N   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_tick,
  input  logic               start,
  input  logic               stop,
  input  logic               src_sel,
  input  logic               oneshot,
  input  logic [1:0]         mode,
  input  logic [3:0]         max_steps,
  input  logic [TIMER_W-1:0] period,
  output logic [3:0]         step_out,
  output logic               dac_wr,
  output logic               busy,
  output logic               cycle_done,
  output logic [1:0]         state_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;

  localparam logic [3:0] MAX_N_L = 4'(MAX_N);

  logic               start_q, stop_q;
  logic [1:0]         state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic               dir_up_q, dir_up_d;
  logic [3:0]         n_q, n_d;
  logic [1:0]         mode_q, mode_d;
  logic               one_q, one_d;
  logic               src_q, src_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               wr_q, wr_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               start_e, stop_e;
  logic [3:0]         n_eff;
  logic [1:0]         mode_eff;
  logic [3:0]         start_val;
  logic [TIMER_W-1:0] period_m1;
  logic               tmr_exp, adv, load;
  logic [3:0]         nxt_step;
  logic               nxt_dir_up, wrap;

  assign start_e   = start & ~start_q;
  assign stop_e    = stop & ~stop_q;
  assign n_eff     = (max_steps == 4'd0) ? 4'd1 :
                     ((max_steps > MAX_N_L) ? MAX_N_L : max_steps);
  assign mode_eff  = (mode == 2'd3) ? MODE_UP : mode;
  assign start_val = (mode_eff == MODE_DOWN) ? (n_eff - 4'd1) : 4'd0;
  // Period 0 behaves as 1. Using >= keeps the timer bounded if period is
  // lowered while the timer is already past the new terminal count.
  assign period_m1 = (period == '0) ? '0 : (period - 1'b1);
  assign tmr_exp   = (timer_q >= period_m1);
  assign adv       = src_q ? tmr_exp : ext_tick;

  // Next step in the latched sweep shape, and whether this move closes a period.
  always_comb begin
    nxt_step   = step_q;
    nxt_dir_up = dir_up_q;
    wrap       = 1'b0;
    case (mode_q)
      MODE_DOWN: begin
        if (step_q == 4'd0) begin
          nxt_step = n_q - 4'd1;
          wrap     = 1'b1;
        end else begin
          nxt_step = step_q - 4'd1;
        end
      end
      MODE_TRI: begin
        if (n_q == 4'd1) begin
          nxt_step = 4'd0;
          wrap     = 1'b1;
        end else if (dir_up_q && (step_q != n_q - 4'd1)) begin
          nxt_step = step_q + 4'd1;
        end else begin
          // Descending (or turning at the top): reaching 0 ends the period
          // and turns the sweep upward again without repeating 0.
          nxt_step   = step_q - 4'd1;
          wrap       = (step_q == 4'd1);
          nxt_dir_up = (step_q == 4'd1);
        end
      end
      default: begin
        if (step_q == n_q - 4'd1) begin
          nxt_step = 4'd0;
          wrap     = 1'b1;
        end else begin
          nxt_step = step_q + 4'd1;
        end
      end
    endcase
  end

  // Sequencer FSM: command edges, advance handling, and run-parameter latching.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dir_up_d = dir_up_q;
    n_d      = n_q;
    mode_d   = mode_q;
    one_d    = one_q;
    src_d    = src_q;
    timer_d  = '0;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load = start_e & ~stop_e;
      end
      ST_RUN: begin
        if (stop_e) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = tmr_exp ? '0 : (timer_q + 1'b1);
          if (adv) begin
            step_d   = nxt_step;
            dir_up_d = nxt_dir_up;
            wr_d     = 1'b1;
            done_d   = wrap;
            if (wrap && one_q) begin
              state_d = ST_HOLD;
              timer_d = '0;
            end
          end
        end
      end
      ST_HOLD: begin
        if (stop_e) begin
          state_d = ST_IDLE;
        end else begin
          load = start_e;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (load) begin
      state_d  = ST_RUN;
      step_d   = start_val;
      dir_up_d = 1'b1;
      n_d      = n_eff;
      mode_d   = mode_eff;
      one_d    = oneshot;
      src_d    = src_sel;
      timer_d  = '0;
      wr_d     = 1'b1;
    end
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      state_q  <= ST_IDLE;
      step_q   <= 4'd0;
      dir_up_q <= 1'b1;
      n_q      <= 4'd1;
      mode_q   <= MODE_UP;
      one_q    <= 1'b0;
      src_q    <= 1'b0;
      timer_q  <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      start_q  <= start;
      stop_q   <= stop;
      state_q  <= state_d;
      step_q   <= step_d;
      dir_up_q <= dir_up_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      one_q    <= one_d;
      src_q    <= src_d;
      timer_q  <= timer_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign step_out   = step_q;
  assign dac_wr     = wr_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_step_sweep_controller.sv
// Bench for step_sweep_controller: directed scenarios plus randomized runs,
// every cycle compared against a sweep-table reference model.
module tb_step_sweep_controller;

  localparam int TW   = 24;
  localparam int MAXN = 10;

  logic          clk = 1'b0;
  logic          rst, ext_tick, start, stop, src_sel, oneshot;
  logic [1:0]    mode;
  logic [3:0]    max_steps;
  logic [TW-1:0] period;
  logic [3:0]    step_out;
  logic          dac_wr, busy, cycle_done;
  logic [1:0]    state_out;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  // Reference model: sweep as an explicit table of values, walked by index.
  int m_state, m_pos, m_len, m_tcnt, m_src, m_one;
  int seq[20];
  bit m_pstart, m_pstop, m_wr, m_done;

  // clock / reset block
  always #5 clk = ~clk;

  step_sweep_controller #(.TIMER_W(TW), .MAX_N(MAXN)) dut (
    .clk(clk), .rst(rst), .ext_tick(ext_tick), .start(start), .stop(stop),
    .src_sel(src_sel), .oneshot(oneshot), .mode(mode), .max_steps(max_steps),
    .period(period), .step_out(step_out), .dac_wr(dac_wr), .busy(busy),
    .cycle_done(cycle_done), .state_out(state_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic build_seq(input int n, input int md);
    int k;
    k = 0;
    if (md == 1) begin
      for (int i = 0; i < n; i++) seq[i] = n - 1 - i;
      m_len = n;
    end else if (md == 2 && n > 1) begin
      for (int i = 0; i < n; i++) seq[k++] = i;
      for (int j = n - 2; j >= 1; j--) seq[k++] = j;
      m_len = k;
    end else begin
      for (int i = 0; i < n; i++) seq[i] = i;
      m_len = n;
    end
  endtask

  task automatic model_load();
    int n, md;
    n  = (max_steps == 0) ? 1 : ((int'(max_steps) > MAXN) ? MAXN : int'(max_steps));
    md = (mode == 2'd3) ? 0 : int'(mode);
    build_seq(n, md);
    m_src   = int'(src_sel);
    m_one   = int'(oneshot);
    m_pos   = 0;
    m_tcnt  = 0;
    m_state = 1;
    m_wr    = 1'b1;
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_eval();
    bit se, pe, adv;
    int p;
    m_wr   = 1'b0;
    m_done = 1'b0;
    if (!rst) begin
      m_state = 0; m_pos = 0; m_len = 1; seq[0] = 0; m_tcnt = 0;
      m_pstart = 1'b0; m_pstop = 1'b0;
      return;
    end
    se = start && !m_pstart;
    pe = stop && !m_pstop;
    m_pstart = start;
    m_pstop  = stop;
    p = (period == 0) ? 1 : int'(period);
    case (m_state)
      0: if (se && !pe) model_load();
      1: begin
        if (pe) begin
          m_state = 0;
          m_tcnt  = 0;
        end else begin
          adv = m_src ? (m_tcnt >= p - 1) : ext_tick;
          m_tcnt = (m_tcnt >= p - 1) ? 0 : m_tcnt + 1;
          if (adv) begin
            m_pos = (m_pos + 1) % m_len;
            m_wr  = 1'b1;
            if (m_pos == 0) begin
              m_done = 1'b1;
              if (m_one) begin
                m_state = 2;
                m_tcnt  = 0;
              end
            end
          end
        end
      end
      default: begin
        if (pe) m_state = 0;
        else if (se) model_load();
      end
    endcase
  endtask

  // driver: inputs were set by the caller; advance one clock and score it
  task automatic step_clk();
    logic [8:0] e;
    model_eval();
    exp_q.push_back({2'(m_state), (m_state == 1), m_wr, m_done, 4'(seq[m_pos])});
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("state_out",  state_out,  e[8:7]);
    check_eq("busy",       busy,       e[6]);
    check_eq("dac_wr",     dac_wr,     e[5]);
    check_eq("cycle_done", cycle_done, e[4]);
    check_eq("step_out",   step_out,   e[3:0]);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic pulse_start();
    start = 1'b1; step_clk();
    start = 1'b0; step_clk();
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step_clk();
    stop = 1'b0; step_clk();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ext_tick = 1'b1; step_clk();
      ext_tick = 1'b0; step_clk();
    end
  endtask

  task automatic cfg(input bit s, input bit o, input logic [1:0] md, input logic [3:0] ms, input int p);
    src_sel = s; oneshot = o; mode = md; max_steps = ms; period = TW'(p);
  endtask

  initial begin
    rst = 1'b0; ext_tick = 1'b0; start = 1'b0; stop = 1'b0;
    cfg(1'b0, 1'b0, 2'd0, 4'd3, 4);
    idle_n(3);
    rst = 1'b1;
    idle_n(2);

    // internal timer, up-saw N=3, period 4
    cfg(1'b1, 1'b0, 2'd0, 4'd3, 4);
    pulse_start();
    idle_n(18);
    check_eq("tp1_busy", busy, 1);
    pulse_stop();

    // triangle N=4 on external ticks
    cfg(1'b0, 1'b0, 2'd2, 4'd4, 4);
    pulse_start();
    ticks(9);
    pulse_stop();

    // oneshot down-saw, max_steps clipped to 10
    cfg(1'b0, 1'b1, 2'd1, 4'd12, 4);
    pulse_start();
    ticks(14);
    check_eq("tp3_hold_state", state_out, 2);
    check_eq("tp3_hold_step", step_out, 9);
    pulse_start();
    ticks(3);
    pulse_stop();

    // start and stop edges together from IDLE
    start = 1'b1; stop = 1'b1; step_clk();
    start = 1'b0; stop = 1'b0; step_clk();
    check_eq("tp4_still_idle", state_out, 0);
    // stop coincident with a tick during RUN
    cfg(1'b0, 1'b0, 2'd0, 4'd8, 4);
    pulse_start();
    ticks(3);
    stop = 1'b1; ext_tick = 1'b1; step_clk();
    stop = 1'b0; ext_tick = 1'b0; step_clk();
    check_eq("tp4_stop_step", step_out, 3);

    // N=1, period 0: advance every cycle
    cfg(1'b1, 1'b0, 2'd0, 4'd0, 0);
    pulse_start();
    idle_n(6);
    pulse_stop();

    // reset mid-sweep; max_steps change during RUN ignored
    cfg(1'b0, 1'b0, 2'd0, 4'd10, 4);
    pulse_start();
    ticks(5);
    check_eq("tp6_pre_rst_step", step_out, 5);
    rst = 1'b0; step_clk();
    rst = 1'b1; step_clk();
    check_eq("tp6_rst_step", step_out, 0);
    cfg(1'b0, 1'b0, 2'd0, 4'd4, 4);
    pulse_start();
    max_steps = 4'd9;
    ticks(6);
    pulse_stop();

    // randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)), $urandom_range(0, 6));
      pulse_start();
      for (int c = 0; c < $urandom_range(60, 200); c++) begin
        ext_tick = ($urandom_range(0, 2) == 0);
        stop     = ($urandom_range(0, 90) == 0);
        start    = ($urandom_range(0, 50) == 0);
        rst      = ($urandom_range(0, 400) != 0);
        if ($urandom_range(0, 20) == 0) max_steps = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 20) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 30) == 0) src_sel = ~src_sel;
        if ($urandom_range(0, 30) == 0) oneshot = ~oneshot;
        step_clk();
      end
      start = 1'b0; stop = 1'b0; ext_tick = 1'b0; rst = 1'b1;
      step_clk();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
